// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program-counter and fetch-request generator with BOOT/RUN/HALT
//            control, redirect/exception steering and misalignment trapping.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int              INSTR_BYTES  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [1:0]      pcsrc,
  input  logic [XLEN-1:0] bta,
  input  logic [XLEN-1:0] jta,
  input  logic [XLEN-1:0] regfile,
  input  logic            exc_valid,
  input  logic            halt_req,
  input  logic            resume,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err,
  output logic [XLEN-1:0] epc
);

  localparam logic [XLEN-1:0] c_incr = XLEN'(INSTR_BYTES);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] w_epc_nxt;
  logic            r_misalign;
  logic            w_misalign_nxt;
  logic            r_boot_armed;
  logic [XLEN-1:0] w_target;
  logic            w_redirect;

  // r_boot_armed keeps BOOT occupied for one full cycle after reset release,
  // so the first fetch request appears on the second non-reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_misalign   <= 1'b0;
      r_boot_armed <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_epc        <= w_epc_nxt;
      r_misalign   <= w_misalign_nxt;
      r_boot_armed <= 1'b1;
    end
  end

  always_comb begin
    w_target = bta;
    case (pcsrc)
      2'b01:   w_target = bta;
      2'b10:   w_target = jta;
      2'b11:   w_target = regfile;
      default: w_target = bta;
    endcase
  end

  // pcsrc==00 is not a redirect; redirects only take effect while running.
  assign w_redirect = redirect_valid && (pcsrc != 2'b00) && (r_state == RUN);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_epc_nxt      = r_epc;
    w_misalign_nxt = 1'b0;
    if (exc_valid) begin
      w_state_nxt = RUN;
      w_pc_nxt    = EXC_VECTOR;
      w_epc_nxt   = r_pc;
    end else if (w_redirect) begin
      if (w_target[1:0] != 2'b00) begin
        w_pc_nxt       = EXC_VECTOR;
        w_epc_nxt      = w_target;
        w_misalign_nxt = 1'b1;
      end else begin
        w_pc_nxt = w_target;
      end
    end else begin
      case (r_state)
        BOOT: begin
          if (r_boot_armed) w_state_nxt = RUN;
        end
        RUN: begin
          if (halt_req) begin
            w_state_nxt = HALT;
          end else if (fetch_ready && !stall) begin
            w_pc_nxt = pc_plus4;
          end
        end
        HALT: begin
          if (resume) w_state_nxt = RUN;
        end
        default: w_state_nxt = BOOT;
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = r_pc + c_incr;
  assign epc          = r_epc;
  assign misalign_err = r_misalign;
  assign fetch_valid  = (r_state == RUN);

endmodule
`default_nettype wire
